// File: rtl/icrc_arbiter_if.sv
// AXI4-Stream bundle of N parallel 512-bit lanes (N=1 for a single stream).
interface icrc_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0][511:0] tdata;
    logic [N-1:0][63:0]  tkeep;
    logic [N-1:0]        tlast;
    logic [N-1:0]        tvalid;
    logic [N-1:0]        tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/icrc_arbiter.sv
// Packet round-robin arbiter in front of icrc, tagging each packet's owner; optional ICRC_ARB_WATCHDOG_EN.
// Latency: grant and tag one cycle after tvalid in IDLE; BUSY data path is combinational.
// Backpressure: granted tready mirrors engine tready; one IDLE bubble per packet; full tag FIFO blocks grants.
module icrc_arbiter #(
    parameter int  N_REQ     = 4,
    parameter int  TAG_DEPTH = 8,
    parameter int  WD_CYCLES = 1024,
    localparam int IDW       = $clog2(N_REQ),
    localparam int PW        = $clog2(TAG_DEPTH)
) (
    input  logic           nclk,
    input  logic           nresetn,
    icrc_arbiter_if.slave  s_axis_req,
    icrc_arbiter_if.master m_axis_icrc,
    output logic           m_tag_valid,
    output logic [IDW-1:0] m_tag_id,
    input  logic           m_tag_ready,
    output logic           err_stall
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last;
    logic [IDW-1:0] scan;
    logic [IDW-1:0] pick;
    logic           pick_vld;
    logic           win;
    logic           hs;
    logic           hs_last;
    logic           tag_full;
    logic           pop;
    logic [IDW-1:0] mem [TAG_DEPTH];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;

    // First valid requester after the most recent grant, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        scan     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan = IDW'((int'(last) + k) % N_REQ);
            if (!pick_vld && s_axis_req.tvalid[scan]) begin
                pick_vld = 1'b1;
                pick     = scan;
            end
        end
    end

    assign win     = (state == IDLE) && pick_vld && !tag_full;
    assign hs      = (state == BUSY) && s_axis_req.tvalid[grant] && m_axis_icrc.tready[0];
    assign hs_last = hs && s_axis_req.tlast[grant];

    always_comb begin
        m_axis_icrc.tdata[0]     = s_axis_req.tdata[grant];
        m_axis_icrc.tkeep[0]     = s_axis_req.tkeep[grant];
        m_axis_icrc.tlast[0]     = s_axis_req.tlast[grant];
        m_axis_icrc.tvalid[0]    = (state == BUSY) && s_axis_req.tvalid[grant];
        s_axis_req.tready        = '0;
        s_axis_req.tready[grant] = (state == BUSY) && m_axis_icrc.tready[0];
    end

    always_ff @(posedge nclk or negedge nresetn) begin
        if (!nresetn) begin
            state <= IDLE;
            grant <= '0;
            last  <= IDW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: if (win) begin
                    state <= BUSY;
                    grant <= pick;
                    last  <= pick;
                end
                BUSY: if (hs_last) state <= IDLE;
            endcase
        end
    end

    // Tag FIFO: extra pointer MSB separates full from empty.
    assign tag_full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign m_tag_valid = (wr_ptr != rd_ptr);
    assign m_tag_id    = mem[rd_ptr[PW-1:0]];
    assign pop         = m_tag_valid && m_tag_ready;

    always_ff @(posedge nclk or negedge nresetn) begin
        if (!nresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (win) begin
                mem[wr_ptr[PW-1:0]] <= pick;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

`ifdef ICRC_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;
    logic           wd_err;
    logic           stall;
    logic           wd_hit;

    assign stall  = (state == BUSY) && !s_axis_req.tvalid[grant];
    assign wd_hit = stall && (wd_cnt == WDW'(WD_CYCLES - 1));

    always_ff @(posedge nclk or negedge nresetn) begin
        if (!nresetn) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (win || hs)
                wd_cnt <= '0;
            else if (stall && !wd_err)
                wd_cnt <= wd_cnt + WDW'(1);
            if (wd_hit) wd_err <= 1'b1;
        end
    end

    // Flag shows in the stall cycle that reaches the threshold; the grant is kept.
    assign err_stall = wd_err || wd_hit;
`else
    logic wd_unused;
    assign wd_unused = (WD_CYCLES > 0);
    assign err_stall = 1'b0;
`endif
endmodule

// File: tb/tb_icrc_arbiter.sv
// Bench for icrc_arbiter: vector table, directed corner sequences, random run against a queue model.
module tb_icrc_arbiter;
    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int WD    = 16;

    logic       nclk    = 1'b0;
    logic       nresetn = 1'b1;
    logic       m_tag_valid;
    logic [1:0] m_tag_id;
    logic       m_tag_ready;
    logic       err_stall;

    icrc_arbiter_if #(.N(N)) req_if ();
    icrc_arbiter_if #(.N(1)) eng_if ();

    icrc_arbiter #(.N_REQ(N), .TAG_DEPTH(DEPTH), .WD_CYCLES(WD)) dut (
        .nclk        (nclk),
        .nresetn     (nresetn),
        .s_axis_req  (req_if),
        .m_axis_icrc (eng_if),
        .m_tag_valid (m_tag_valid),
        .m_tag_id    (m_tag_id),
        .m_tag_ready (m_tag_ready),
        .err_stall   (err_stall)
    );

    always #5 nclk = ~nclk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        nresetn        = 1'b0;
        req_if.tvalid  = '0;
        req_if.tlast   = '0;
        req_if.tdata   = '0;
        req_if.tkeep   = '0;
        eng_if.tready  = '0;
        m_tag_ready    = 1'b0;
        repeat (2) @(posedge nclk);
        #1 nresetn = 1'b1;
    endtask

    typedef struct packed {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       mrdy;
        logic       trdy;
        logic [3:0] e_rdy;
        logic       e_mvld;
        logic       e_tvld;
        logic [1:0] e_tid;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic mr, logic tr,
                                logic [3:0] er, logic em, logic et, logic [1:0] ei);
        vec_t x;
        x = '{rst: r, vld: v, lst: l, mrdy: mr, trdy: tr, e_rdy: er, e_mvld: em, e_tvld: et, e_tid: ei};
        return x;
    endfunction

    vec_t tbl [26];

    // Random-run state: source beats and the reference model.
    logic [N-1:0] sv, sl;
    logic [511:0] sd [N];
    logic [63:0]  sk [N];
    int           left [N];
    bit           mb;
    int           mg, ml;
    int           tq [$];

    initial begin
        logic [511:0] bd [4];
        logic [63:0]  bk [3];
        logic [5:0]   mr_pat;
        int           acc;

        // Round-robin with two-beat packets, then tag-FIFO-full with single-beat packets.
        tbl[0]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        tbl[1]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h1, 1, 1, 0);
        tbl[2]  = mk(0, 4'hF, 4'h1, 1, 1, 4'h1, 1, 0, 0);
        tbl[3]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        tbl[4]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h2, 1, 1, 1);
        tbl[5]  = mk(0, 4'hF, 4'h2, 1, 1, 4'h2, 1, 0, 0);
        tbl[6]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        tbl[7]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h4, 1, 1, 2);
        tbl[8]  = mk(0, 4'hF, 4'h4, 1, 1, 4'h4, 1, 0, 0);
        tbl[9]  = mk(0, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        tbl[10] = mk(0, 4'hF, 4'h0, 1, 1, 4'h8, 1, 1, 3);
        tbl[11] = mk(0, 4'hF, 4'h8, 1, 1, 4'h8, 1, 0, 0);
        tbl[12] = mk(0, 4'hF, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        tbl[13] = mk(0, 4'hF, 4'h0, 1, 1, 4'h1, 1, 1, 0);
        tbl[14] = mk(1, 4'hE, 4'hE, 1, 0, 4'h0, 0, 0, 0);
        tbl[15] = mk(0, 4'hE, 4'hE, 1, 0, 4'h2, 1, 1, 1);
        tbl[16] = mk(0, 4'hC, 4'hC, 1, 0, 4'h0, 0, 1, 1);
        tbl[17] = mk(0, 4'hC, 4'hC, 1, 0, 4'h4, 1, 1, 1);
        tbl[18] = mk(0, 4'h8, 4'h8, 1, 0, 4'h0, 0, 1, 1);
        tbl[19] = mk(0, 4'h8, 4'h8, 1, 0, 4'h0, 0, 1, 1);
        tbl[20] = mk(0, 4'h8, 4'h8, 1, 1, 4'h0, 0, 1, 1);
        tbl[21] = mk(0, 4'h8, 4'h8, 1, 0, 4'h0, 0, 1, 2);
        tbl[22] = mk(0, 4'h8, 4'h8, 1, 0, 4'h8, 1, 1, 2);
        tbl[23] = mk(0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 1, 2);
        tbl[24] = mk(0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 1, 3);
        tbl[25] = mk(0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);

        // Reset state with every input pushing for activity.
        req_if.tvalid = '1; req_if.tlast = '0; req_if.tdata = '0; req_if.tkeep = '0;
        eng_if.tready = 1'b1; m_tag_ready = 1'b1;
        #1 nresetn = 1'b0;
        #11;
        chk("rst_mvld", eng_if.tvalid, 1'b0);
        chk("rst_rdy", req_if.tready, 4'h0);
        chk("rst_tvld", m_tag_valid, 1'b0);
        chk("rst_tid", m_tag_id, 2'd0);
        chk("rst_err", err_stall, 1'b0);
        do_reset();

        for (int r = 0; r < 26; r++) begin
            if (tbl[r].rst) do_reset();
            req_if.tvalid = tbl[r].vld;
            req_if.tlast  = tbl[r].lst;
            eng_if.tready = tbl[r].mrdy;
            m_tag_ready   = tbl[r].trdy;
            @(negedge nclk);
            chk($sformatf("row%0d_rdy", r), req_if.tready, tbl[r].e_rdy);
            chk($sformatf("row%0d_mvld", r), eng_if.tvalid, tbl[r].e_mvld);
            chk($sformatf("row%0d_tvld", r), m_tag_valid, tbl[r].e_tvld);
            if (tbl[r].e_tvld) chk($sformatf("row%0d_tid", r), m_tag_id, tbl[r].e_tid);
            @(posedge nclk); #1;
        end

        // Single requester, three beats, partial keep on the last.
        do_reset();
        for (int b = 0; b < 3; b++) bd[b] = rnd512();
        bk[0] = '1; bk[1] = '1; bk[2] = 64'h000000ffffffffff;
        req_if.tvalid = 4'b0001; req_if.tdata[0] = bd[0]; req_if.tkeep[0] = bk[0];
        eng_if.tready = 1'b1;
        @(negedge nclk);
        chk("sr_idle_mvld", eng_if.tvalid, 1'b0);
        chk("sr_idle_rdy", req_if.tready, 4'h0);
        @(posedge nclk); #1;
        for (int b = 0; b < 3; b++) begin
            req_if.tdata[0] = bd[b]; req_if.tkeep[0] = bk[b]; req_if.tlast = {3'b000, b == 2};
            @(negedge nclk);
            chk($sformatf("sr_b%0d_mvld", b), eng_if.tvalid, 1'b1);
            chk($sformatf("sr_b%0d_data", b), eng_if.tdata, bd[b]);
            chk($sformatf("sr_b%0d_keep", b), eng_if.tkeep, bk[b]);
            chk($sformatf("sr_b%0d_last", b), eng_if.tlast, b == 2);
            chk($sformatf("sr_b%0d_rdy", b), req_if.tready, 4'b0001);
            chk($sformatf("sr_b%0d_tvld", b), m_tag_valid, 1'b1);
            chk($sformatf("sr_b%0d_tid", b), m_tag_id, 2'd0);
            @(posedge nclk); #1;
        end
        req_if.tvalid = '0;
        @(negedge nclk);
        chk("sr_bubble_mvld", eng_if.tvalid, 1'b0);
        m_tag_ready = 1'b1;
        @(posedge nclk); #1;
        m_tag_ready = 1'b0;
        @(negedge nclk);
        chk("sr_popped", m_tag_valid, 1'b0);

        // Back-pressure on a four-beat req2 packet while all others wait.
        do_reset();
        for (int b = 0; b < 4; b++) bd[b] = rnd512();
        req_if.tvalid = 4'b0100; req_if.tdata[2] = bd[0]; eng_if.tready = 1'b1;
        @(posedge nclk); #1;
        req_if.tvalid = 4'b1111;
        mr_pat = 6'b111001;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            eng_if.tready   = mr_pat[c];
            req_if.tdata[2] = bd[acc & 3];
            req_if.tlast    = {1'b0, acc == 3, 2'b00};
            @(negedge nclk);
            chk($sformatf("bp_c%0d_rdy", c), req_if.tready, mr_pat[c] ? 4'b0100 : 4'b0000);
            chk($sformatf("bp_c%0d_mvld", c), eng_if.tvalid, 1'b1);
            chk($sformatf("bp_c%0d_data", c), eng_if.tdata, bd[acc & 3]);
            if (mr_pat[c] && req_if.tready[2]) acc++;
            @(posedge nclk); #1;
        end
        chk("bp_beats", acc, 4);
        req_if.tvalid = 4'b1011; req_if.tlast = '0;
        @(negedge nclk);
        chk("bp_bubble_mvld", eng_if.tvalid, 1'b0);
        chk("bp_bubble_rdy", req_if.tready, 4'h0);
        @(posedge nclk); #1;

        // Reset during beat 2 of a req1 packet.
        do_reset();
        bd[0] = rnd512(); bd[1] = rnd512(); bd[2] = rnd512();
        req_if.tvalid = 4'b0010; req_if.tdata[1] = bd[0]; eng_if.tready = 1'b1;
        @(posedge nclk); #1;
        @(negedge nclk);
        chk("rm_b1_rdy", req_if.tready, 4'b0010);
        @(posedge nclk); #1;
        req_if.tdata[1] = bd[1];
        #2 nresetn = 1'b0;
        #1;
        chk("rm_mvld", eng_if.tvalid, 1'b0);
        chk("rm_rdy", req_if.tready, 4'h0);
        chk("rm_tvld", m_tag_valid, 1'b0);
        chk("rm_tid", m_tag_id, 2'd0);
        chk("rm_err", err_stall, 1'b0);
        @(posedge nclk); #1;
        nresetn = 1'b1;
        req_if.tvalid = 4'b0011; req_if.tdata[0] = bd[2]; req_if.tdata[1] = bd[0];
        @(negedge nclk);
        chk("rm_idle_rdy", req_if.tready, 4'h0);
        @(posedge nclk); #1;
        @(negedge nclk);
        chk("rm_first_rdy", req_if.tready, 4'b0001);
        chk("rm_first_data", eng_if.tdata, bd[2]);
        @(posedge nclk); #1;

`ifdef ICRC_ARB_WATCHDOG_EN
        // Req3 stalls mid-packet long enough to trip the watchdog.
        do_reset();
        req_if.tvalid = 4'b1000; req_if.tdata[3] = rnd512(); eng_if.tready = 1'b1;
        @(posedge nclk); #1;
        @(negedge nclk);
        chk("wd_b1_rdy", req_if.tready, 4'b1000);
        @(posedge nclk); #1;
        req_if.tvalid = '0;
        for (int s = 1; s <= 20; s++) begin
            @(negedge nclk);
            chk($sformatf("wd_stall%0d", s), err_stall, s >= WD);
            @(posedge nclk); #1;
        end
        req_if.tvalid = 4'b1000; req_if.tlast = 4'b1000;
        @(negedge nclk);
        chk("wd_b2_rdy", req_if.tready, 4'b1000);
        chk("wd_b2_err", err_stall, 1'b1);
        @(posedge nclk); #1;
        req_if.tvalid = '0; req_if.tlast = '0;
        @(negedge nclk);
        chk("wd_done_mvld", eng_if.tvalid, 1'b0);
        chk("wd_done_err", err_stall, 1'b1);
        @(posedge nclk); #1;
`endif

        // Random traffic against the queue model.
        do_reset();
        sv = '0; sl = '0; mb = 0; ml = N - 1; mg = 0; tq.delete();
        for (int i = 0; i < N; i++) begin left[i] = 0; sd[i] = '0; sk[i] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       mr;
            logic [3:0] er;
            logic       emv;
            bit         tpop;
            int         gnew;
            for (int i = 0; i < N; i++) begin
                if (!sv[i] && $urandom_range(0, 2) == 0) begin
                    if (left[i] == 0) left[i] = $urandom_range(1, 4);
                    sv[i] = 1'b1;
                    sd[i] = rnd512();
                    sk[i] = {$urandom, $urandom};
                    sl[i] = (left[i] == 1);
                end
                req_if.tdata[i] = sd[i];
                req_if.tkeep[i] = sk[i];
            end
            req_if.tvalid = sv;
            req_if.tlast  = sl;
            mr            = ($urandom_range(0, 3) != 0);
            eng_if.tready = mr;
            m_tag_ready   = $urandom_range(0, 1);
            @(negedge nclk);
            er  = '0;
            emv = 1'b0;
            if (mb) begin
                emv    = sv[mg];
                er[mg] = mr;
            end
            chk("rnd_rdy", req_if.tready, er);
            chk("rnd_mvld", eng_if.tvalid, emv);
            if (emv) begin
                chk("rnd_data", eng_if.tdata, sd[mg]);
                chk("rnd_keep", eng_if.tkeep, sk[mg]);
                chk("rnd_last", eng_if.tlast, sl[mg]);
            end
            chk("rnd_tvld", m_tag_valid, tq.size() != 0);
            if (tq.size() != 0) chk("rnd_tid", m_tag_id, tq[0]);
`ifndef ICRC_ARB_WATCHDOG_EN
            chk("rnd_err", err_stall, 1'b0);
`endif
            tpop = (tq.size() != 0) && m_tag_ready;
            gnew = -1;
            if (!mb) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (ml + k) % N;
                    if (gnew < 0 && sv[idx] && tq.size() < DEPTH) gnew = idx;
                end
            end else if (sv[mg] && mr) begin
                sv[mg] = 1'b0;
                left[mg]--;
                if (sl[mg]) mb = 0;
            end
            if (tpop) void'(tq.pop_front());
            if (gnew >= 0) begin
                mb = 1;
                mg = gnew;
                ml = gnew;
                tq.push_back(gnew);
            end
            @(posedge nclk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
